// File: rtl/ctrl_pipe.sv
// Control-word pipeline for a 5-stage in-order core.
// Carries decoded controls from ID through EX, MEM and WB, inserts bubbles on
// load-use stalls, taken branches, invalid or illegal ID slots, and counts
// inserted bubbles in a saturating counter.
module ctrl_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] ctrl_id,
    input  logic       valid_id,
    input  logic       illegal_id,
    input  logic       stall,
    input  logic       zero_ex,
    output logic       ex_regdst,
    output logic       ex_alusrc,
    output logic       ex_branch,
    output logic [1:0] ex_aluop,
    output logic       mem_memwrite,
    output logic       mem_memtoreg,
    output logic       mem_regwrite,
    output logic       wb_regwrite,
    output logic       wb_memtoreg,
    output logic       ex_valid,
    output logic       mem_valid,
    output logic       wb_valid,
    output logic       pcsrc_ex,
    output logic       jump_id,
    output logic       illegal_ex,
    output logic [7:0] bubble_cnt
);

    // ctrl_id field positions
    localparam int unsigned BitRegWrite = 8;
    localparam int unsigned BitRegDst   = 7;
    localparam int unsigned BitAluSrc   = 6;
    localparam int unsigned BitBranch   = 5;
    localparam int unsigned BitMemWrite = 4;
    localparam int unsigned BitMemToReg = 3;
    localparam int unsigned BitJump     = 2;

    // ID/EX register
    logic       idex_valid_q,    idex_valid_d;
    logic       idex_regwrite_q, idex_regwrite_d;
    logic       idex_regdst_q,   idex_regdst_d;
    logic       idex_alusrc_q,   idex_alusrc_d;
    logic       idex_branch_q,   idex_branch_d;
    logic       idex_memwrite_q, idex_memwrite_d;
    logic       idex_memtoreg_q, idex_memtoreg_d;
    logic [1:0] idex_aluop_q,    idex_aluop_d;

    // EX/MEM register
    logic       exmem_valid_q,    exmem_valid_d;
    logic       exmem_regwrite_q, exmem_regwrite_d;
    logic       exmem_memwrite_q, exmem_memwrite_d;
    logic       exmem_memtoreg_q, exmem_memtoreg_d;

    // MEM/WB register
    logic       memwb_valid_q,    memwb_valid_d;
    logic       memwb_regwrite_q, memwb_regwrite_d;
    logic       memwb_memtoreg_q, memwb_memtoreg_d;

    logic       illegal_q, illegal_d;
    logic [7:0] bubble_cnt_q, bubble_cnt_d;

    logic       insert_bubble;
    logic       redirect_bubble;

    // Branch resolution in EX and jump redirect in ID, both zero-latency
    always_comb begin
        pcsrc_ex = idex_valid_q & idex_branch_q & zero_ex;
        jump_id  = valid_id & ctrl_id[BitJump] & ~illegal_id & ~stall & ~pcsrc_ex;
    end

    // Next-state for all stage registers, illegal flag and bubble counter
    always_comb begin
        // stall and squash together still count as one bubble
        redirect_bubble = stall | pcsrc_ex;
        insert_bubble   = redirect_bubble | ~valid_id | illegal_id;

        idex_valid_d    = 1'b0;
        idex_regwrite_d = 1'b0;
        idex_regdst_d   = 1'b0;
        idex_alusrc_d   = 1'b0;
        idex_branch_d   = 1'b0;
        idex_memwrite_d = 1'b0;
        idex_memtoreg_d = 1'b0;
        idex_aluop_d    = 2'b00;
        if (!insert_bubble) begin
            idex_valid_d    = 1'b1;
            idex_regwrite_d = ctrl_id[BitRegWrite];
            idex_regdst_d   = ctrl_id[BitRegDst];
            idex_alusrc_d   = ctrl_id[BitAluSrc];
            idex_branch_d   = ctrl_id[BitBranch];
            idex_memwrite_d = ctrl_id[BitMemWrite];
            idex_memtoreg_d = ctrl_id[BitMemToReg];
            idex_aluop_d    = ctrl_id[1:0];
        end

        // Later stages always advance; a stall only affects what enters EX
        exmem_valid_d    = idex_valid_q;
        exmem_regwrite_d = idex_regwrite_q;
        exmem_memwrite_d = idex_memwrite_q;
        exmem_memtoreg_d = idex_memtoreg_q;

        memwb_valid_d    = exmem_valid_q;
        memwb_regwrite_d = exmem_regwrite_q;
        memwb_memtoreg_d = exmem_memtoreg_q;

        // Flag only when the illegal op actually issues (not held, not squashed)
        illegal_d = valid_id & illegal_id & ~redirect_bubble;

        bubble_cnt_d = bubble_cnt_q;
        if (valid_id && redirect_bubble && (bubble_cnt_q != 8'hFF)) begin
            bubble_cnt_d = bubble_cnt_q + 8'd1;
        end
    end

    // State update with synchronous active-low reset to all-bubble pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_valid_q     <= 1'b0;
            idex_regwrite_q  <= 1'b0;
            idex_regdst_q    <= 1'b0;
            idex_alusrc_q    <= 1'b0;
            idex_branch_q    <= 1'b0;
            idex_memwrite_q  <= 1'b0;
            idex_memtoreg_q  <= 1'b0;
            idex_aluop_q     <= 2'b00;
            exmem_valid_q    <= 1'b0;
            exmem_regwrite_q <= 1'b0;
            exmem_memwrite_q <= 1'b0;
            exmem_memtoreg_q <= 1'b0;
            memwb_valid_q    <= 1'b0;
            memwb_regwrite_q <= 1'b0;
            memwb_memtoreg_q <= 1'b0;
            illegal_q        <= 1'b0;
            bubble_cnt_q     <= 8'd0;
        end else begin
            idex_valid_q     <= idex_valid_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_regdst_q    <= idex_regdst_d;
            idex_alusrc_q    <= idex_alusrc_d;
            idex_branch_q    <= idex_branch_d;
            idex_memwrite_q  <= idex_memwrite_d;
            idex_memtoreg_q  <= idex_memtoreg_d;
            idex_aluop_q     <= idex_aluop_d;
            exmem_valid_q    <= exmem_valid_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            exmem_memwrite_q <= exmem_memwrite_d;
            exmem_memtoreg_q <= exmem_memtoreg_d;
            memwb_valid_q    <= memwb_valid_d;
            memwb_regwrite_q <= memwb_regwrite_d;
            memwb_memtoreg_q <= memwb_memtoreg_d;
            illegal_q        <= illegal_d;
            bubble_cnt_q     <= bubble_cnt_d;
        end
    end

    // Stage outputs; gated by valid so a stage never drives stale controls
    always_comb begin
        ex_valid     = idex_valid_q;
        ex_regdst    = idex_valid_q & idex_regdst_q;
        ex_alusrc    = idex_valid_q & idex_alusrc_q;
        ex_branch    = idex_valid_q & idex_branch_q;
        ex_aluop     = idex_valid_q ? idex_aluop_q : 2'b00;
        mem_valid    = exmem_valid_q;
        mem_memwrite = exmem_valid_q & exmem_memwrite_q;
        mem_memtoreg = exmem_valid_q & exmem_memtoreg_q;
        mem_regwrite = exmem_valid_q & exmem_regwrite_q;
        wb_valid     = memwb_valid_q;
        wb_regwrite  = memwb_valid_q & memwb_regwrite_q;
        wb_memtoreg  = memwb_valid_q & memwb_memtoreg_q;
        illegal_ex   = illegal_q;
        bubble_cnt   = bubble_cnt_q;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe.
module tb_ctrl_pipe;

    localparam logic [8:0] CtrlLw    = 9'b101001000;
    localparam logic [8:0] CtrlSw    = 9'b001010000;
    localparam logic [8:0] CtrlRtype = 9'b110000010;
    localparam logic [8:0] CtrlBeq   = 9'b000100001;
    localparam logic [8:0] CtrlJ     = 9'b000000100;

    logic       clk;
    logic       rst_n;
    logic [8:0] ctrl_id;
    logic       valid_id;
    logic       illegal_id;
    logic       stall;
    logic       zero_ex;
    logic       ex_regdst, ex_alusrc, ex_branch;
    logic [1:0] ex_aluop;
    logic       mem_memwrite, mem_memtoreg, mem_regwrite;
    logic       wb_regwrite, wb_memtoreg;
    logic       ex_valid, mem_valid, wb_valid;
    logic       pcsrc_ex, jump_id, illegal_ex;
    logic [7:0] bubble_cnt;

    int unsigned n_total;
    int unsigned n_bad;

    ctrl_pipe u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_id      (ctrl_id),
        .valid_id     (valid_id),
        .illegal_id   (illegal_id),
        .stall        (stall),
        .zero_ex      (zero_ex),
        .ex_regdst    (ex_regdst),
        .ex_alusrc    (ex_alusrc),
        .ex_branch    (ex_branch),
        .ex_aluop     (ex_aluop),
        .mem_memwrite (mem_memwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .wb_memtoreg  (wb_memtoreg),
        .ex_valid     (ex_valid),
        .mem_valid    (mem_valid),
        .wb_valid     (wb_valid),
        .pcsrc_ex     (pcsrc_ex),
        .jump_id      (jump_id),
        .illegal_ex   (illegal_ex),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic ill, input logic st,
                         input logic z);
        valid_id   = v;
        ctrl_id    = c;
        illegal_id = ill;
        stall      = st;
        zero_ex    = z;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
        check_eq("rst_illegal_ex", 32'(illegal_ex), 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_pcsrc", 32'(pcsrc_ex), 32'd0);
        check_eq("post_rst_jump", 32'(jump_id), 32'd0);

        // LW through EX, MEM, WB
        drive(1'b1, CtrlLw, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        check_eq("lw_ex_valid", 32'(ex_valid), 32'd1);
        check_eq("lw_ex_alusrc", 32'(ex_alusrc), 32'd1);
        step();
        check_eq("lw_mem_memtoreg", 32'(mem_memtoreg), 32'd1);
        check_eq("lw_mem_regwrite", 32'(mem_regwrite), 32'd1);
        check_eq("lw_ex_valid_gone", 32'(ex_valid), 32'd0);
        step();
        check_eq("lw_wb_regwrite", 32'(wb_regwrite), 32'd1);
        check_eq("lw_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
        check_eq("lw_mem_regwrite_gone", 32'(mem_regwrite), 32'd0);

        // Stall bubble behind SW
        drive(1'b1, CtrlSw, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, CtrlRtype, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("stall_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("stall_ex_regdst", 32'(ex_regdst), 32'd0);
        check_eq("stall_mem_memwrite", 32'(mem_memwrite), 32'd1);
        check_eq("stall_bubble_cnt", 32'(bubble_cnt), 32'd1);
        drive(1'b1, CtrlRtype, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("rtype_ex_valid", 32'(ex_valid), 32'd1);
        check_eq("rtype_ex_aluop", 32'(ex_aluop), 32'd2);
        check_eq("rtype_ex_regdst", 32'(ex_regdst), 32'd1);
        check_eq("rtype_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Taken branch squashes ID
        drive(1'b1, CtrlBeq, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("beq_ex_branch", 32'(ex_branch), 32'd1);
        drive(1'b1, CtrlRtype, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("beq_pcsrc_taken", 32'(pcsrc_ex), 32'd1);
        step();
        check_eq("beq_squash_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("beq_squash_cnt", 32'(bubble_cnt), 32'd2);

        // Not-taken branch leaves ID alone
        drive(1'b1, CtrlBeq, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, CtrlRtype, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("beq_pcsrc_nt", 32'(pcsrc_ex), 32'd0);
        step();
        check_eq("beq_nt_ex_valid", 32'(ex_valid), 32'd1);
        check_eq("beq_nt_cnt", 32'(bubble_cnt), 32'd2);

        // Jump redirect, suppressed by stall
        drive(1'b1, CtrlJ, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("j_jump_id", 32'(jump_id), 32'd1);
        stall = 1'b1;
        #1;
        check_eq("j_jump_stalled", 32'(jump_id), 32'd0);
        stall = 1'b0;
        step();

        // Illegal op issues: one-cycle flag, bubble in EX, no count
        drive(1'b1, CtrlRtype, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        check_eq("ill_flag", 32'(illegal_ex), 32'd1);
        check_eq("ill_ex_valid", 32'(ex_valid), 32'd0);
        step();
        check_eq("ill_flag_clear", 32'(illegal_ex), 32'd0);
        check_eq("ill_cnt", 32'(bubble_cnt), 32'd2);

        // Illegal op held by stall, flagged once it issues
        drive(1'b1, CtrlRtype, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("ill_stall_flag", 32'(illegal_ex), 32'd0);
        check_eq("ill_stall_cnt", 32'(bubble_cnt), 32'd3);
        stall = 1'b0;
        step();
        drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        check_eq("ill_release_flag", 32'(illegal_ex), 32'd1);

        // Saturation over 300 stall cycles
        drive(1'b1, CtrlRtype, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check_eq("sat_cnt", 32'(bubble_cnt), 32'd255);

        // Load a branch into EX, then reset mid-stall and mid-branch
        drive(1'b1, CtrlBeq, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, CtrlRtype, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        step();
        check_eq("rst2_cnt", 32'(bubble_cnt), 32'd0);
        check_eq("rst2_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst2_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst2_wb_valid", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, CtrlJ, 1'b0, 1'b0, 1'b1);
        #1;
        check_eq("rst2_pcsrc", 32'(pcsrc_ex), 32'd0);
        check_eq("rst2_jump", 32'(jump_id), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
